main: RTL and testbench

MAIN -- requirements
Module: main

---
 rtl/main_pkg.sv | 59 +++++
 rtl/main_tone_gen.sv | 30 +++
 rtl/main.sv | 83 ++++++++
 tb/tb_main.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/main_pkg.sv
// Note encoding, tone frequency table, half-period helper and song ROM for the melody player.
package main_pkg;

    typedef logic [1:0] oct_t;
    typedef logic [2:0] deg_t;

    typedef struct packed {
        oct_t oct;
        deg_t deg;
    } note_t;

    localparam oct_t OCT_REST = 2'd0;
    localparam oct_t OCT_LOW  = 2'd1;
    localparam oct_t OCT_MID  = 2'd2;
    localparam oct_t OCT_HIGH = 2'd3;

    localparam int unsigned NUM_TONES = 21;

    // low do..si, mid do..si, high do..si
    localparam int unsigned FREQ_TAB [NUM_TONES] = '{
        262, 294, 330, 349, 392, 440, 494,
        523, 587, 659, 698, 784, 880, 988,
        1047, 1175, 1319, 1397, 1568, 1760, 1976
    };

    localparam logic [4:0] INTRO [8] = '{
        5'h13, 5'h15, 5'h16, 5'h19, 5'h1a, 5'h16, 5'h19, 5'h00
    };

    localparam logic [4:0] MELODY [16] = '{
        5'h0d, 5'h0e, 5'h11, 5'h12, 5'h13, 5'h00, 5'h15, 5'h19,
        5'h1b, 5'h17, 5'h16, 5'h15, 5'h0f, 5'h11, 5'h00, 5'h11
    };

    function automatic int unsigned half_period(int unsigned clk_hz, int unsigned freq);
        return clk_hz / (2 * freq);
    endfunction

    // Index into FREQ_TAB; rests and malformed codes fall back to entry 0.
    function automatic logic [4:0] tone_idx(note_t n);
        logic [4:0] idx;
        idx = 5'(n.oct) * 5'd7 + 5'(n.deg) - 5'd8;
        if (n.oct == OCT_REST || n.deg == 3'd0 || idx >= 5'(NUM_TONES)) begin
            idx = '0;
        end
        return idx;
    endfunction

    // Entries past the intro cycle through the 16-entry melody.
    function automatic note_t song_rom(int unsigned i);
        logic [31:0] rel;
        rel = i - 32'd8;
        if (i < 8) begin
            return note_t'(INTRO[i[2:0]]);
        end
        return note_t'(MELODY[rel[3:0]]);
    endfunction

endpackage

// File: rtl/main_tone_gen.sv
// Square-wave tone divider: toggles spk every hp cycles, phase-restarted on each beat.
module main_tone_gen #(
    parameter int unsigned HPW = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           restart,
    input  logic           rest,
    input  logic [HPW-1:0] hp,
    output logic           spk
);

    logic [HPW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            spk   <= 1'b0;
        end else if (restart || rest) begin
            cnt_q <= '0;
            spk   <= 1'b0;
        end else if (cnt_q == hp - 1'b1) begin
            cnt_q <= '0;
            spk   <= ~spk;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/main.sv
// Melody player: steps through the song ROM once per beat, drives LED/H and a speaker tone.
// Define MAIN_SONG_LOOP_EN to loop the song; otherwise playback stops at rest after the last entry.
module main
    import main_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 25_000_000,
    parameter int unsigned BEAT_HZ  = 4,
    parameter int unsigned SONG_LEN = 64
) (
    input  logic       CLK0,
    input  logic       RST0,
    output logic [3:0] LED,
    output logic       SPK_KX,
    output logic       H
);

    localparam int unsigned BEAT_DIV = CLK_HZ / BEAT_HZ;
    localparam int unsigned BW       = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
    localparam int unsigned PW       = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;
    localparam int unsigned HPW      = $clog2(half_period(CLK_HZ, FREQ_TAB[0]) + 1);

    logic [BW-1:0]  beat_cnt_q;
    logic [PW-1:0]  ptr_q;
    logic           done_q;
    logic           tick;
    note_t          note;
    logic           rest;
    logic [HPW-1:0] hp_tab [NUM_TONES];
    logic [HPW-1:0] hp;

    for (genvar i = 0; i < NUM_TONES; i++) begin : g_hp
        localparam int unsigned HPV = half_period(CLK_HZ, FREQ_TAB[i]);
        assign hp_tab[i] = HPW'(HPV);
    end

    assign tick = (beat_cnt_q == BW'(BEAT_DIV - 1));
    assign note = song_rom(32'(ptr_q));
    assign rest = done_q || (note.oct == OCT_REST);
    assign hp   = hp_tab[tone_idx(note)];

    always_ff @(posedge CLK0 or posedge RST0) begin
        if (RST0) begin
            beat_cnt_q <= '0;
            ptr_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            beat_cnt_q <= tick ? '0 : beat_cnt_q + 1'b1;
            if (tick) begin
                if (ptr_q == PW'(SONG_LEN - 1)) begin
`ifdef MAIN_SONG_LOOP_EN
                    ptr_q <= '0;
`else
                    done_q <= 1'b1;
`endif
                end else begin
                    ptr_q <= ptr_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK0 or posedge RST0) begin
        if (RST0) begin
            LED <= 4'd0;
            H   <= 1'b0;
        end else begin
            LED <= rest ? 4'd0 : {1'b0, note.deg};
            H   <= !rest && (note.oct == OCT_HIGH);
        end
    end

    main_tone_gen #(
        .HPW(HPW)
    ) u_tone (
        .clk    (CLK0),
        .rst    (RST0),
        .restart(tick),
        .rest   (rest),
        .hp     (hp),
        .spk    (SPK_KX)
    );

endmodule

// File: tb/tb_main.sv
// Scoreboard bench for main: a per-edge reference model derived from elapsed beats and cycles.
module tb_main;

    // Faster beat and short song keep the whole run well under 100k cycles.
    localparam int unsigned CLK_HZ   = 1_000_000;
    localparam int unsigned BEAT_HZ  = 250;
    localparam int unsigned SONG_LEN = 12;
    localparam int unsigned D        = CLK_HZ / BEAT_HZ;

    localparam int unsigned FREQ [21] = '{
        262, 294, 330, 349, 392, 440, 494,
        523, 587, 659, 698, 784, 880, 988,
        1047, 1175, 1319, 1397, 1568, 1760, 1976
    };
    // M3 M5 M6 H1 H2 M6 H1 REST
    localparam int unsigned OCT0 [8] = '{2, 2, 2, 3, 3, 2, 3, 0};
    localparam int unsigned DEG0 [8] = '{3, 5, 6, 1, 2, 6, 1, 0};

    typedef struct {
        int unsigned k;
        logic [5:0]  v;
    } exp_t;

    logic       CLK0;
    logic       RST0;
    logic [3:0] LED;
    logic       SPK_KX;
    logic       H;

    exp_t        exp_q [$];
    int unsigned k;
    int          vectors;
    int          miscompares;

    main #(
        .CLK_HZ  (CLK_HZ),
        .BEAT_HZ (BEAT_HZ),
        .SONG_LEN(SONG_LEN)
    ) dut (
        .CLK0  (CLK0),
        .RST0  (RST0),
        .LED   (LED),
        .SPK_KX(SPK_KX),
        .H     (H)
    );

    initial begin
        CLK0 = 1'b0;
        forever #5 CLK0 = ~CLK0;
    end

    // Expected {LED, H, SPK_KX} after the k-th rising edge since reset release.
    function automatic logic [5:0] model(int unsigned kk);
        int unsigned p, m, idx, oct, deg, hp;
        logic [4:0]  code;
        logic [3:0]  led;
        logic        h, spk, rst_note;
        if (kk == 0) return 6'd0;
        p = (kk - 1) / D;
        m = kk - p * D;
`ifdef MAIN_SONG_LOOP_EN
        idx      = p % SONG_LEN;
        rst_note = 1'b0;
`else
        idx      = (p < SONG_LEN) ? p : SONG_LEN - 1;
        rst_note = (p >= SONG_LEN);
`endif
        if (idx < 8) begin
            oct = OCT0[idx];
            deg = DEG0[idx];
        end else begin
            code = main_pkg::song_rom(idx);
            oct  = int'(code[4:3]);
            deg  = int'(code[2:0]);
        end
        if (oct == 0) rst_note = 1'b1;
        led = rst_note ? 4'd0 : 4'(deg);
        h   = !rst_note && (oct == 3);
        spk = 1'b0;
        if (!rst_note && m != D) begin
            hp  = CLK_HZ / (2 * FREQ[(oct - 1) * 7 + deg - 1]);
            spk = ((m / hp) % 2) == 1;
        end
        return {led, h, spk};
    endfunction

    task automatic run(int unsigned n);
        exp_t e;
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge CLK0);
            if (!RST0) k++;
            #1;
            e.k = k;
            e.v = model(k);
            exp_q.push_back(e);
        end
    endtask

    initial begin : monitor
        exp_t       e;
        logic [5:0] act;
        forever begin
            @(negedge CLK0);
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                act = {LED, H, SPK_KX};
                vectors++;
                if (act !== e.v) begin
                    miscompares++;
                    if (miscompares <= 10)
                        $display("FAIL outputs edge=%0d actual led=%0d h=%b spk=%b required led=%0d h=%b spk=%b",
                                 e.k, act[5:2], act[1], act[0], e.v[5:2], e.v[1], e.v[0]);
                end
            end
        end
    end

    initial begin : stim
        exp_t        e;
        int unsigned r;
        vectors     = 0;
        miscompares = 0;
        k           = 0;
        RST0        = 1'b1;
        run(5);
        RST0 = 1'b0;
        // Full song plus one extra beat: covers wrap (or stop-at-rest) and the rest beat.
        run(SONG_LEN * D + D + 50);

        // Restart from reset, then hit reset asynchronously in the middle of beat 2.
        RST0 = 1'b1;
        k    = 0;
        run(3);
        RST0 = 1'b0;
        r = $urandom_range(200, D - 200);
        run(2 * D + r);
        RST0 = 1'b1;
        k    = 0;
        #1;
        vectors++;
        if ({LED, H, SPK_KX} !== 6'd0) begin
            miscompares++;
            $display("FAIL async_reset actual led=%0d h=%b spk=%b required all zero", LED, H, SPK_KX);
        end
        e   = exp_q.pop_back();
        e.k = 0;
        e.v = 6'd0;
        exp_q.push_back(e);
        run($urandom_range(1, 4));
        RST0 = 1'b0;
        run(D + 1000);

        repeat (2) @(negedge CLK0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
